// File: rtl/mm_tile_controller.sv
// Tiled matrix-multiply controller: sequences SxS tiles over an MxN result, streams K operand words per tile
// and drains each tile to buffer P through a decoupled writer. Optional counters: MM_TILE_CTRL_PERF_EN.
module mm_tile_controller #(
  parameter int ARRAY_SIZE = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int OUTPUT_LAT = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         m_i,
  input  logic [ADDR_WIDTH-1:0]         k_i,
  input  logic [ADDR_WIDTH-1:0]         n_i,
  input  logic [ADDR_WIDTH-1:0]         base_a_i,
  input  logic [ADDR_WIDTH-1:0]         base_b_i,
  input  logic [ADDR_WIDTH-1:0]         base_p_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          pe_clr_o,
  output logic                          pe_we_o,
  output logic                          ensys_o,
  output logic                          bubble_o,
  output logic                          ena_o,
  output logic                          enb_o,
  output logic [ADDR_WIDTH-1:0]         addra_o,
  output logic [ADDR_WIDTH-1:0]         addrb_o,
  output logic                          enp_o,
  output logic                          wep_o,
  output logic [ADDR_WIDTH-1:0]         addrp_o,
  output logic [$clog2(ARRAY_SIZE)-1:0] wordp_sel_o,
  output logic [$clog2(ARRAY_SIZE)-1:0] datap_sel_o
`ifdef MM_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                   cyc_cnt_o,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int AW    = ADDR_WIDTH;
  localparam int SEL_W = $clog2(ARRAY_SIZE);
  localparam int TW    = SEL_W + 1;
  localparam int CW    = $clog2(OUTPUT_LAT + ARRAY_SIZE + 1);
  localparam logic [TW-1:0] S_TW = TW'(ARRAY_SIZE);
  localparam logic [AW-1:0] S_AW = AW'(ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_BUSY, W_DONE} wstate_t;

  state_t        state;
  wstate_t       wstate;
  logic [AW-1:0] batch_cycle;
  logic [AW-1:0] row_tile;
  logic [AW-1:0] col_tile;
  logic [AW-1:0] row_off;
  logic [AW-1:0] col_off;
  logic          all_read_done;
  logic          err;

  // Tile geometry travels alongside pe_we_o so the writer latches the tile that just finished.
  logic [TW-1:0] tm_pipe;
  logic [TW-1:0] tn_pipe;
  logic          last_pipe;

  logic [TW-1:0] wtm;
  logic [TW-1:0] wtn;
  logic          wlast;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] addrp;

  logic          zero_dim;
  logic          start_go;
  logic [AW-1:0] tmax;
  logic          last_batch;
  logic          last_row;
  logic          last_col;
  logic          at_we;
  logic          rd_ok;
  logic          stall;
  logic          rd_en;
  logic [TW-1:0] cur_tm;
  logic [TW-1:0] cur_tn;
  logic          wait_last;
  logic          wbusy_last;

  assign zero_dim   = (m_i == '0) || (k_i == '0) || (n_i == '0);
  assign start_go   = (state == IDLE) && start_i && !zero_dim;
  assign tmax       = (k_i > S_AW) ? k_i : S_AW;
  assign last_batch = (batch_cycle == tmax - AW'(1));
  assign last_row   = (row_tile == ((m_i - AW'(1)) >> SEL_W));
  assign last_col   = (col_tile == ((n_i - AW'(1)) >> SEL_W));
  assign at_we      = (batch_cycle == k_i - AW'(1));
  assign rd_ok      = (state == BUSY) && !all_read_done;
  // Only the pe_we cycle may stall: a new tile result cannot be latched while the writer still drains.
  assign stall      = rd_ok && at_we && (wstate != W_IDLE);
  assign rd_en      = rd_ok && !stall;

  assign cur_tm = (last_row && (m_i[SEL_W-1:0] != '0)) ? {1'b0, m_i[SEL_W-1:0]} : S_TW;
  assign cur_tn = (last_col && (n_i[SEL_W-1:0] != '0)) ? {1'b0, n_i[SEL_W-1:0]} : S_TW;

  assign wait_last  = (wcnt == CW'(OUTPUT_LAT) + CW'(wtm) - CW'(1));
  assign wbusy_last = (wcnt == CW'(wtn) - CW'(1));

  assign busy_o      = (state == BUSY);
  assign done_o      = (state == DONE);
  assign err_o       = err;
  assign enp_o       = (wstate == W_BUSY);
  assign wep_o       = (wstate == W_BUSY);
  assign addrp_o     = addrp;
  assign wordp_sel_o = (wstate == W_BUSY) ? wcnt[SEL_W-1:0] : '0;
  assign datap_sel_o = wtm[SEL_W-1:0];

  // Main sequencer, tile/cycle counters and registered read-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      batch_cycle   <= '0;
      row_tile      <= '0;
      col_tile      <= '0;
      row_off       <= '0;
      col_off       <= '0;
      all_read_done <= 1'b0;
      err           <= 1'b0;
      tm_pipe       <= '0;
      tn_pipe       <= '0;
      last_pipe     <= 1'b0;
      ena_o         <= 1'b0;
      enb_o         <= 1'b0;
      ensys_o       <= 1'b0;
      pe_clr_o      <= 1'b0;
      pe_we_o       <= 1'b0;
      bubble_o      <= 1'b0;
      addra_o       <= '0;
      addrb_o       <= '0;
    end else begin
      ena_o     <= rd_en;
      enb_o     <= rd_en;
      ensys_o   <= rd_en;
      pe_clr_o  <= rd_en && (batch_cycle == '0);
      pe_we_o   <= rd_en && at_we;
      bubble_o  <= rd_en && (batch_cycle >= k_i);
      addra_o   <= rd_en ? (base_a_i + row_off + batch_cycle) : '0;
      addrb_o   <= rd_en ? (base_b_i + col_off + batch_cycle) : '0;
      tm_pipe   <= cur_tm;
      tn_pipe   <= cur_tn;
      last_pipe <= last_row && last_col;

      case (state)
        IDLE: begin
          if (start_i) begin
            if (zero_dim) begin
              state <= DONE;
              err   <= 1'b1;
            end else begin
              state         <= BUSY;
              err           <= 1'b0;
              batch_cycle   <= '0;
              row_tile      <= '0;
              col_tile      <= '0;
              row_off       <= '0;
              col_off       <= '0;
              all_read_done <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (rd_en) begin
            if (last_batch) begin
              batch_cycle <= '0;
              if (last_col) begin
                col_tile <= '0;
                col_off  <= '0;
                if (last_row) begin
                  all_read_done <= 1'b1;
                end else begin
                  row_tile <= row_tile + AW'(1);
                  row_off  <= row_off + k_i;
                end
              end else begin
                col_tile <= col_tile + AW'(1);
                col_off  <= col_off + k_i;
              end
            end else begin
              batch_cycle <= batch_cycle + AW'(1);
            end
          end
          if (all_read_done && (wstate == W_DONE) && wlast) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!start_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result writer: waits for the array pipeline plus row skew, then emits tn contiguous P words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate <= W_IDLE;
      wtm    <= '0;
      wtn    <= '0;
      wlast  <= 1'b0;
      wcnt   <= '0;
      addrp  <= '0;
    end else begin
      if (start_go) begin
        addrp <= base_p_i;
      end else if (wstate == W_BUSY) begin
        addrp <= addrp + AW'(1);
      end

      case (wstate)
        W_IDLE: begin
          if (pe_we_o) begin
            wtm    <= tm_pipe;
            wtn    <= tn_pipe;
            wlast  <= last_pipe;
            wcnt   <= '0;
            wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wait_last) begin
            wcnt   <= '0;
            wstate <= W_BUSY;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        W_BUSY: begin
          if (wbusy_last) begin
            wcnt   <= '0;
            wstate <= W_DONE;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        W_DONE:  wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

`ifdef MM_TILE_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else if (start_go) begin
      cyc_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else if (state == BUSY) begin
      if (cyc_cnt_o != '1) cyc_cnt_o <= cyc_cnt_o + 32'd1;
      if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_tile_controller.sv
// Scoreboard bench for mm_tile_controller: expected A/B reads and P writes are derived from the tiling
// rules with plain arithmetic and checked by an independent monitor as the DUT presents them.
module tb_mm_tile_controller;
  localparam int S  = 8;
  localparam int AW = 16;
  localparam int OL = 3;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] m = '0, k = '0, n = '0, ba = '0, bb = '0, bp = '0;
  logic          busy_o, done_o, err_o, pe_clr_o, pe_we_o, ensys_o, bubble_o, ena_o, enb_o, enp_o, wep_o;
  logic [AW-1:0] addra_o, addrb_o, addrp_o;
  logic [2:0]    wordp_sel_o, datap_sel_o;
`ifdef MM_TILE_CTRL_PERF_EN
  logic [31:0]   cyc_cnt_o, stall_cnt_o;
`endif

  mm_tile_controller #(.ARRAY_SIZE(S), .ADDR_WIDTH(AW), .OUTPUT_LAT(OL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start),
    .m_i(m), .k_i(k), .n_i(n), .base_a_i(ba), .base_b_i(bb), .base_p_i(bp),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .pe_clr_o(pe_clr_o), .pe_we_o(pe_we_o),
    .ensys_o(ensys_o), .bubble_o(bubble_o), .ena_o(ena_o), .enb_o(enb_o),
    .addra_o(addra_o), .addrb_o(addrb_o), .enp_o(enp_o), .wep_o(wep_o), .addrp_o(addrp_o),
    .wordp_sel_o(wordp_sel_o), .datap_sel_o(datap_sel_o)
`ifdef MM_TILE_CTRL_PERF_EN
    , .cyc_cnt_o(cyc_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [AW-1:0] b; logic clr; logic we; logic bub; int tile; } rd_t;
  typedef struct { logic [AW-1:0] p; logic [2:0] w; logic [2:0] d; int tile; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  ena_low_busy = 0;
  int  busy_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: tiles in row-major order, T=max(k,S) reads per tile, tn contiguous writes per tile.
  task automatic build_model(input int mv, input int kv, input int nv, input int bav, input int bbv, input int bpv);
    int rr, cc, tt, tm, tn, t, cnt;
    rd_t r_e;
    wr_t w_e;
    rr = (mv + S - 1) / S;
    cc = (nv + S - 1) / S;
    tt = (kv > S) ? kv : S;
    t = 0;
    cnt = 0;
    for (int r = 0; r < rr; r++) begin
      for (int c = 0; c < cc; c++) begin
        tm = (r == rr - 1 && mv % S != 0) ? mv % S : S;
        tn = (c == cc - 1 && nv % S != 0) ? nv % S : S;
        for (int b = 0; b < tt; b++) begin
          r_e.a = AW'(bav + r * kv + b);
          r_e.b = AW'(bbv + c * kv + b);
          r_e.clr = (b == 0);
          r_e.we = (b == kv - 1);
          r_e.bub = (b >= kv);
          r_e.tile = t;
          rd_q.push_back(r_e);
        end
        for (int w = 0; w < tn; w++) begin
          w_e.p = AW'(bpv + cnt);
          w_e.w = 3'(w);
          w_e.d = 3'(tm % S);
          w_e.tile = t;
          wr_q.push_back(w_e);
          cnt++;
        end
        t++;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or a write.
  always @(negedge clk) begin
    rd_t r_e;
    wr_t w_e;
    if (rst_ni) begin
      if (busy_o) busy_cycles++;
      if (busy_o && !ena_o && rd_q.size() > 0) ena_low_busy++;
      if (ena_o) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", 1, 0);
        end else begin
          r_e = rd_q.pop_front();
          check("read", {addra_o, addrb_o, pe_clr_o, pe_we_o, bubble_o}, {r_e.a, r_e.b, r_e.clr, r_e.we, r_e.bub});
          check("read_en_pair", {ensys_o, enb_o}, 2'b11);
          if (r_e.we) begin
            if (wr_q.size() == 0) check("pe_we_pending_writes", 0, 1);
            else check("pe_we_prev_tile_drained", wr_q[0].tile, r_e.tile);
          end
        end
      end else begin
        check("read_idle", {pe_clr_o, pe_we_o, bubble_o, ensys_o, enb_o, addra_o, addrb_o}, 0);
      end
      if (enp_o) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w_e = wr_q.pop_front();
          check("write", {addrp_o, wordp_sel_o, datap_sel_o, wep_o}, {w_e.p, w_e.w, w_e.d, 1'b1});
        end
      end else begin
        check("write_idle", {wep_o, wordp_sel_o}, 0);
      end
    end
  end

  task automatic all_zero_check(input string name);
    check(name, {busy_o, done_o, err_o, pe_clr_o, pe_we_o, ensys_o, bubble_o, ena_o, enb_o,
                 addra_o, addrb_o, enp_o, wep_o, addrp_o, wordp_sel_o, datap_sel_o}, 0);
  endtask

  task automatic run_case(input int mv, input int kv, input int nv, input int bav, input int bbv, input int bpv,
                          input bit expect_stall, input int abort_after);
    int guard;
    @(negedge clk);
    m = AW'(mv); k = AW'(kv); n = AW'(nv); ba = AW'(bav); bb = AW'(bbv); bp = AW'(bpv);
    build_model(mv, kv, nv, bav, bbv, bpv);
    ena_low_busy = 0;
    busy_cycles = 0;
    start = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!busy_o && guard < 10);
    check("start_to_busy", busy_o, 1);
    start = 1'b0;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      @(posedge clk);
      #2 rst_ni = 1'b0;
      #1 all_zero_check("async_reset_outputs");
      rd_q.delete();
      wr_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      $display("run m=%0d k=%0d n=%0d aborted by reset after %0d cycles", mv, kv, nv, abort_after);
      return;
    end
    guard = 0;
    while (!done_o && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("done_reached", done_o, 1);
    check("reads_remaining", rd_q.size(), 0);
    check("writes_remaining", wr_q.size(), 0);
    check("err_clear", {err_o, busy_o}, 0);
    if (expect_stall) check("stall_seen", (ena_low_busy - 1) > 0, 1);
`ifdef MM_TILE_CTRL_PERF_EN
    check("stall_cnt", stall_cnt_o, ena_low_busy - 1);
    check("cyc_cnt", cyc_cnt_o, busy_cycles);
`endif
    $display("run m=%0d k=%0d n=%0d ba=%0h bb=%0h bp=%0h busy=%0d stalls=%0d", mv, kv, nv, bav, bbv, bpv,
             busy_cycles, ena_low_busy - 1);
    @(negedge clk);
    check("done_to_idle", done_o, 0);
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic zero_case(input int mv, input int kv, input int nv);
    @(negedge clk);
    m = AW'(mv); k = AW'(kv); n = AW'(nv);
    start = 1'b1;
    @(negedge clk);
    check("zero_done", {done_o, err_o, busy_o}, 3'b110);
    @(negedge clk);
    check("zero_hold_done", {done_o, err_o}, 2'b11);
    start = 1'b0;
    @(negedge clk);
    check("zero_back_idle_err_held", {done_o, err_o, busy_o}, 3'b010);
    $display("zero-dim run m=%0d k=%0d n=%0d err=%0d", mv, kv, nv, err_o);
  endtask

  initial begin
    #12;
    all_zero_check("reset_state");
    @(negedge clk);
    rst_ni = 1'b1;
    run_case(8, 8, 8, 16'h0100, 16'h0200, 16'h0300, 1'b0, 0);
    run_case(9, 4, 17, 16'h1000, 16'h2000, 16'h3000, 1'b1, 0);
    run_case(16, 8, 16, 16'hFFF8, 16'h0040, 16'hFFFC, 1'b1, 0);
    zero_case(8, 0, 8);
    zero_case(0, 3, 5);
    run_case(4, 3, 5, 16'h0010, 16'h0020, 16'h0030, 1'b0, 0);
    check("err_cleared_by_restart", err_o, 0);
    run_case(16, 8, 16, 16'h0500, 16'h0600, 16'h0700, 1'b0, 30);
    run_case(8, 8, 8, 16'h0100, 16'h0200, 16'h0300, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      run_case($urandom_range(1, 20), $urandom_range(1, 12), $urandom_range(1, 20),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               1'b0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
